// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared constants, opcode/class/state enums for the instruction sequencer
package instr_sequencer_pkg;

    localparam int WORD_SIZE    = 19;
    localparam int ADDR_W_DEF   = 12;
    localparam int OPCODE_W_DEF = 4;
    localparam int LSEL_W_DEF   = 3;

    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_IR   = 3'd1;
    localparam logic [2:0] LOAD_ACC  = 3'd2;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LOAD   = 4'h1,
        OP_STORE  = 4'h2,
        OP_ALU_LO = 4'h3,
        OP_ALU_HI = 4'h7,
        OP_JMP    = 4'h8,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU,
        CLS_JMP,
        CLS_HLT
    } op_class_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD_IR,
        S_DEC_WAIT,
        S_DECODE,
        S_MEM_RD,
        S_WB,
        S_MEM_WR,
        S_ALU_GO,
        S_ALU_WAIT,
        S_JUMP,
        S_HALT,
        S_FAULT
    } seq_state_t;

    // States that wait on an external completion and may time out.
    function automatic logic is_wait_state(seq_state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR) || (s == S_ALU_WAIT);
    endfunction

endpackage

// File: rtl/seq_opcode_decode.sv
// rtl/seq_opcode_decode.sv - combinational opcode to operation-class decoder
module seq_opcode_decode
    import instr_sequencer_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output op_class_t           op_class_o
);

    always_comb begin
        op_class_o = CLS_NOP;
        if (opcode_i == OPCODE_W'(OP_LOAD)) begin
            op_class_o = CLS_LOAD;
        end else if (opcode_i == OPCODE_W'(OP_STORE)) begin
            op_class_o = CLS_STORE;
        end else if ((opcode_i >= OPCODE_W'(OP_ALU_LO)) && (opcode_i <= OPCODE_W'(OP_ALU_HI))) begin
            op_class_o = CLS_ALU;
        end else if (opcode_i == OPCODE_W'(OP_JMP)) begin
            op_class_o = CLS_JMP;
        end else if (opcode_i == OPCODE_W'(OP_HLT)) begin
            op_class_o = CLS_HLT;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute controller for the 19-bit CPU
// Optional wait-state timeout to FAULT enabled by SEQ_TIMEOUT_EN.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int OPCODE_W       = OPCODE_W_DEF,
    parameter int LSEL_W         = LSEL_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [ADDR_W-1:0]   pc_value,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    output logic                load_reg,
    output logic [LSEL_W-1:0]   load_select,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic [ADDR_W-1:0]   ir_operand,
    output logic                alu_go,
    input  logic                alu_done,
    output logic                busy,
    output logic                halted,
    output logic                fault
);

    seq_state_t        state_q, state_d;
    op_class_t         op_class;
    logic              ack_taken;
    logic              timeout_hit;

    logic              pc_inc_q, pc_inc_d;
    logic              pc_load_q, pc_load_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              load_reg_q, load_reg_d;
    logic [LSEL_W-1:0] load_select_q, load_select_d;
    logic              alu_go_q, alu_go_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;

    seq_opcode_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode_i   (ir_opcode),
        .op_class_o (op_class)
    );

    // An ack only completes an access while our request is actually outstanding.
    assign ack_taken = mem_ack && mem_req_q;

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = is_wait_state(state_q) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (is_wait_state(state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (ack_taken)        state_d = S_LOAD_IR;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_LOAD_IR:  state_d = S_DEC_WAIT;
            S_DEC_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                case (op_class)
                    CLS_LOAD:  state_d = S_MEM_RD;
                    CLS_STORE: state_d = S_MEM_WR;
                    CLS_ALU:   state_d = S_ALU_GO;
                    CLS_JMP:   state_d = S_JUMP;
                    CLS_HLT:   state_d = S_HALT;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEM_RD: begin
                if (ack_taken)        state_d = S_WB;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_WB:       state_d = S_FETCH;
            S_MEM_WR: begin
                if (ack_taken)        state_d = S_FETCH;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_ALU_GO:   state_d = S_ALU_WAIT;
            S_ALU_WAIT: begin
                if (alu_done)         state_d = S_FETCH;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        pc_inc_d      = 1'b0;
        pc_load_d     = 1'b0;
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        load_reg_d    = 1'b0;
        load_select_d = LSEL_W'(LOAD_NONE);
        alu_go_d      = 1'b0;
        halted_d      = 1'b0;
        fault_d       = 1'b0;
        busy_d        = !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_FAULT));
        case (state_d)
            S_FETCH: begin
                // A STORE completing straight into FETCH leaves one idle cycle on the bus.
                mem_req_d  = !ack_taken;
                mem_addr_d = pc_value;
            end
            S_MEM_RD: begin
                mem_req_d  = 1'b1;
                mem_addr_d = ir_operand;
            end
            S_MEM_WR: begin
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = ir_operand;
            end
            S_LOAD_IR: begin
                load_reg_d    = 1'b1;
                load_select_d = LSEL_W'(LOAD_IR);
                pc_inc_d      = 1'b1;
            end
            S_WB: begin
                load_reg_d    = 1'b1;
                load_select_d = LSEL_W'(LOAD_ACC);
            end
            S_ALU_GO: alu_go_d  = 1'b1;
            S_JUMP:   pc_load_d = 1'b1;
            S_HALT:   halted_d  = 1'b1;
            S_FAULT:  fault_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_inc_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            load_reg_q    <= 1'b0;
            load_select_q <= '0;
            alu_go_q      <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            pc_inc_q      <= pc_inc_d;
            pc_load_q     <= pc_load_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            load_reg_q    <= load_reg_d;
            load_select_q <= load_select_d;
            alu_go_q      <= alu_go_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    assign pc_inc      = pc_inc_q;
    assign pc_load     = pc_load_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign load_reg    = load_reg_q;
    assign load_select = load_select_q;
    assign alu_go      = alu_go_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
`ifdef SEQ_TIMEOUT_EN
    assign fault       = fault_q;
`else
    assign fault       = 1'b0;
`endif

endmodule
